// File: rtl/if_pc_sequencer_if.sv
// Fetch-side bundle between the PC sequencer, the fetch memory and decode.
// The sequencer takes the slave view; its environment takes the master view.
interface if_pc_sequencer_if;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic [31:0] fetch_instr;
  logic        fetch_inv_addr;
  logic [63:0] pc_out;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        halted;
  logic        fault;
  logic [63:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output fetch_instr,
    output fetch_inv_addr,
    input  pc_out,
    input  ifid_valid,
    input  ifid_pc,
    input  ifid_instr,
    input  halted,
    input  fault,
    input  fault_pc,
    input  fetch_count
  );

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  fetch_instr,
    input  fetch_inv_addr,
    output pc_out,
    output ifid_valid,
    output ifid_pc,
    output ifid_instr,
    output halted,
    output fault,
    output fault_pc,
    output fetch_count
  );
endinterface

// File: rtl/if_pc_sequencer.sv
// PC register and fetch sequencing ahead of a combinational fetch memory.
// Handles stall, branch redirect, zero-word halt and bad-address fault.
module if_pc_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter bit          ZERO_HALT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  if_pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] fpc_q, fpc_d;
  if_id_t      ifid_q, ifid_d;
  logic [31:0] cnt_q, cnt_d;

  logic run;
  logic zero_word;
  logic do_br, do_flt, do_hlt, do_stl, do_adv;

  // One-hot action select, resolving the per-cycle priority
  assign run       = (state_q == RUN);
  assign zero_word = ZERO_HALT && (bus.fetch_instr == 32'h0);

  assign do_br  = run && bus.branch_taken;
  assign do_flt = run && !bus.branch_taken
               && bus.fetch_inv_addr;
  assign do_hlt = run && !bus.branch_taken
               && !bus.fetch_inv_addr && zero_word;
  assign do_stl = run && !bus.branch_taken
               && !bus.fetch_inv_addr && !zero_word
               && bus.stall;
  assign do_adv = run && !bus.branch_taken
               && !bus.fetch_inv_addr && !zero_word
               && !bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fpc_d   = fpc_q;
    ifid_d  = ifid_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      do_br: begin
        pc_d         = bus.branch_target;
        ifid_d.valid = 1'b0;
      end
      do_flt: begin
        state_d      = FAULT;
        fpc_d        = pc_q;
        ifid_d.valid = 1'b0;
      end
      do_hlt: begin
        state_d      = HALT;
        ifid_d.valid = 1'b0;
      end
      do_stl: begin
        ifid_d = ifid_q;
      end
      do_adv: begin
        ifid_d.valid = 1'b1;
        ifid_d.pc    = pc_q;
        ifid_d.instr = bus.fetch_instr;
        pc_d         = pc_q + 64'd4;
        if (cnt_q != 32'hFFFF_FFFF)
          cnt_d = cnt_q + 32'd1;
      end
      default: begin
        ifid_d.valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      fpc_q   <= 64'h0;
      ifid_q  <= '0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fpc_q   <= fpc_d;
      ifid_q  <= ifid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.ifid_valid  = ifid_q.valid;
  assign bus.ifid_pc     = ifid_q.pc;
  assign bus.ifid_instr  = ifid_q.instr;
  assign bus.halted      = (state_q == HALT);
  assign bus.fault       = (state_q == FAULT);
  assign bus.fault_pc    = fpc_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: doc/if_pc_sequencer.md
# if_pc_sequencer

Program-counter and fetch-sequencing stage sitting directly upstream of the combinational instruction fetch memory. It owns the architectural PC register, drives the fetch PC, captures the returned instruction into the IF/ID pipeline register, and applies stall, branch-redirect, end-of-program halt and invalid-address fault handling. Its outputs feed the decode stage.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- ZERO_HALT, 1, when 1, fetching word 32'h00000000 ends the program

Ports:
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents this cycle
- branch_taken  input  1  redirect request from the execute stage
- branch_target  input  64  redirect PC, valid when branch_taken=1
- fetch_instr  input  32  instruction returned by the fetch memory for pc_out, same cycle
- fetch_inv_addr  input  1  fetch memory flags pc_out as misaligned or out of range
- pc_out  output  64  registered fetch PC, drives the fetch memory
- ifid_valid  output  1  IF/ID register holds a real instruction
- ifid_pc  output  64  PC of the IF/ID instruction
- ifid_instr  output  32  IF/ID instruction
- halted  output  1  state is HALT
- fault  output  1  state is FAULT
- fault_pc  output  64  PC that raised the fault
- fetch_count  output  32  count of instructions delivered to IF/ID, saturating

## Operation
- States: RUN, HALT, FAULT. HALT and FAULT are terminal until reset.
- Reset: state=RUN, pc_out=RESET_PC, ifid_valid=0, ifid_pc=0, ifid_instr=0, fault_pc=0, fetch_count=0, halted=0, fault=0.
- RUN priority per cycle: branch_taken > fetch_inv_addr > zero-word halt > stall > normal.
- branch_taken=1: pc_out<=branch_target, ifid_valid<=0, which flushes the wrong-path word. This also applies when stall=1, fetch_inv_addr=1 or a zero word is fetched.
- fetch_inv_addr=1: state<=FAULT, fault_pc<=pc_out, ifid_valid<=0, pc_out held.
- ZERO_HALT=1 and fetch_instr==0: state<=HALT, ifid_valid<=0, pc_out held. The zero word is not counted.
- stall=1: pc_out, ifid_valid, ifid_pc, ifid_instr and fetch_count all held.
- Normal: ifid_pc<=pc_out, ifid_instr<=fetch_instr, ifid_valid<=1, pc_out<=pc_out+4 (64-bit, wraps modulo 2^64), fetch_count<=fetch_count+1, saturating at 32'hFFFFFFFF.
- HALT/FAULT: all inputs ignored; ifid_valid=0; pc_out, fault_pc and fetch_count frozen.
- branch_target is not checked here. A misaligned target faults on the following cycle through fetch_inv_addr.

## Timing
- pc_out is registered; the fetch memory is combinational, so fetch_instr and fetch_inv_addr are sampled in the same cycle that pc_out presents.
- Fetch-to-IF/ID latency is 1 cycle. In the cycle after a normal advance, ifid_pc equals the previous pc_out.
- Branch penalty is 1 bubble: the cycle after branch_taken shows ifid_valid=0 and pc_out=branch_target.
- halted and fault assert 1 cycle after the triggering fetch, decoded directly from the state register.
- Reset asserted mid-run takes effect at the next edge and overrides every other input, including a branch in the same cycle.
- stall and branch_taken are sampled only at the rising edge; no combinational path runs from any input to any output.

## Test plan
- Reset then free-run over words 0x00550533, 0x00A50663, 0x00000000:
  - ifid sequence is (0x0, 0x00550533) then (0x4, 0x00A50663).
  - Fetching address 0x8 raises halted=1 with pc_out=0x8 and fetch_count=2.
- branch_taken=1 with target 0x10 in the cycle pc_out=0x4:
  - next cycle pc_out=0x10 and ifid_valid=0.
  - the cycle after that, ifid_pc=0x10; the zero word at 0x8 never causes HALT.
- stall held for 3 cycles at pc_out=0x10: pc_out, ifid_* and fetch_count stay unchanged, then advance to 0x14 one cycle after stall drops.
- branch_target=0x1002 (misaligned) and fetch memory raising fetch_inv_addr:
  - fault=1 and fault_pc=0x1002 one cycle later.
  - subsequent branch_taken pulses leave pc_out at 0x1002.
- Simultaneous branch_taken=1 and fetch_inv_addr=1 at pc_out=0x1000, target 0x4: no fault is raised and pc_out=0x4.
- With fetch_count preloaded near saturation via a long run, or forced in the bench: fetch_count stops at 0xFFFFFFFF. A reset in the middle of the run returns pc_out=RESET_PC and fetch_count=0 on the next cycle.
